price_stats_accumulator: RTL

PRICE_STATS_ACCUMULATOR -- requirements
Module: price_stats_accumulator

---
 rtl/price_stats_accumulator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/price_stats_accumulator.sv
// price_stats_accumulator
//
// Collects one batch of N = 2^N_LOG2 simulated terminal prices and reports the
// batch mean, population variance, minimum, maximum and the number of samples
// strictly below a loss threshold.
//
// Ports:
//   CLK         in   1           clock, all state updates on the rising edge
//   RST         in   1           asynchronous active-high reset
//   iStart      in   1           begin a new batch (honoured only when idle)
//   iThreshold  in   18          loss threshold, captured with an accepted iStart
//   iValid      in   1           iPrice carries a sample this cycle
//   iPrice      in   18          unsigned sample price
//   oBusy       out  1           batch in progress (accumulating or finalising)
//   oDone       out  1           one-cycle completion pulse
//   oMean       out  18          truncated batch mean
//   oVar        out  36          population variance, clamped at zero
//   oMin/oMax   out  18          smallest / largest sample of the batch
//   oLossCount  out  N_LOG2+1    samples strictly below the threshold
module price_stats_accumulator #(
    parameter int unsigned N_LOG2 = 10
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                iStart,
    input  logic [17:0]         iThreshold,
    input  logic                iValid,
    input  logic [17:0]         iPrice,
    output logic                oBusy,
    output logic                oDone,
    output logic [17:0]         oMean,
    output logic [35:0]         oVar,
    output logic [17:0]         oMin,
    output logic [17:0]         oMax,
    output logic [N_LOG2:0]     oLossCount
);

    localparam int unsigned N    = 1 << N_LOG2;
    localparam int unsigned SumW = N_LOG2 + 18;
    localparam int unsigned SqW  = N_LOG2 + 36;
    localparam int unsigned CntW = N_LOG2 + 1;

    typedef enum logic [1:0] {
        Idle,
        Accum,
        Final,
        Done
    } stateE;

    stateE stateQ;
    stateE stateD;

    logic [SumW-1:0] sumQ;
    logic [SqW-1:0]  sumSqQ;
    logic [CntW-1:0] countQ;
    logic [CntW-1:0] lossQ;
    logic [17:0]     minQ;
    logic [17:0]     maxQ;
    logic [17:0]     thresholdQ;

    logic            startBatch;
    logic            accept;
    logic            lastSample;
    logic [35:0]     priceSq;
    logic [17:0]     meanVal;
    logic [35:0]     meanSqVal;
    logic [35:0]     msqVal;
    logic [35:0]     varVal;

    assign startBatch = (stateQ == Idle) && iStart;
    assign accept     = (stateQ == Accum) && iValid;
    // Counter holds N-1 while the final sample is presented; that edge leaves Accum.
    assign lastSample = accept && (countQ == CntW'(N - 1));
    assign priceSq    = 36'(iPrice) * 36'(iPrice);

    // Finalisation arithmetic; only registered while in Final.
    assign meanVal    = 18'(sumQ >> N_LOG2);
    assign msqVal     = 36'(sumSqQ >> N_LOG2);
    assign meanSqVal  = 36'(meanVal) * 36'(meanVal);
    assign varVal     = (msqVal >= meanSqVal) ? (msqVal - meanSqVal) : 36'd0;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ <= Idle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            Idle:    if (iStart) stateD = Accum;
            Accum:   if (lastSample) stateD = Final;
            Final:   stateD = Done;
            Done:    stateD = Idle;
            default: stateD = Idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        oBusy = (stateQ == Accum) || (stateQ == Final);
        oDone = (stateQ == Done);
    end

    // Accumulators and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sumQ       <= '0;
            sumSqQ     <= '0;
            countQ     <= '0;
            lossQ      <= '0;
            minQ       <= '0;
            maxQ       <= '0;
            thresholdQ <= '0;
            oMean      <= '0;
            oVar       <= '0;
            oMin       <= '0;
            oMax       <= '0;
            oLossCount <= '0;
        end else begin
            if (startBatch) begin
                sumQ       <= '0;
                sumSqQ     <= '0;
                countQ     <= '0;
                lossQ      <= '0;
                minQ       <= '1;
                maxQ       <= '0;
                thresholdQ <= iThreshold;
            end
            if (accept) begin
                sumQ   <= sumQ + SumW'(iPrice);
                sumSqQ <= sumSqQ + SqW'(priceSq);
                countQ <= countQ + 1'b1;
                if (iPrice < minQ) minQ <= iPrice;
                if (iPrice > maxQ) maxQ <= iPrice;
                if (iPrice < thresholdQ) lossQ <= lossQ + 1'b1;
            end
            if (stateQ == Final) begin
                oMean      <= meanVal;
                oVar       <= varVal;
                oMin       <= minQ;
                oMax       <= maxQ;
                oLossCount <= lossQ;
            end
        end
    end

endmodule
